// File: rtl/trigger_readout_scheduler_pkg.sv
// Shared types and constants for the trigger readout scheduler.
package trigger_readout_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    localparam int DEFAULT_HEAD_DIFF = 0;
    localparam int DEFAULT_TAIL_DIFF = 10;

    // Number of beats in one readout window (head + trigger beat + tail).
    function automatic int win_len(input int head_diff, input int tail_diff);
        return head_diff + tail_diff + 1;
    endfunction

    // Bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/trigger_readout_scheduler_if.sv
// Trigger, DRAM read and PC framing signals of the readout scheduler.
interface trigger_readout_scheduler_if #(
    parameter int TS_W   = 16,
    parameter int ADDR_W = 25,
    parameter int DATA_W = 256
);
    logic              trig_valid;
    logic [TS_W-1:0]   trig_time_stamp;
    logic              trig_ready;
    logic              trig_overflow;
    logic              DRAM_Read_Enable;
    logic [ADDR_W-1:0] DRAM_Read_Addr;
    logic              DRAM_Read_Ready;
    logic [DATA_W-1:0] DRAM_Read_data;
    logic              DRAM_Read_Valid;
    logic [DATA_W-1:0] PC_data;
    logic              PC_valid;
    logic              PC_sof;
    logic              PC_eof;
    logic              busy;

    // Scheduler side.
    modport master (
        input  trig_valid, trig_time_stamp, DRAM_Read_Ready, DRAM_Read_data, DRAM_Read_Valid,
        output trig_ready, trig_overflow, DRAM_Read_Enable, DRAM_Read_Addr,
               PC_data, PC_valid, PC_sof, PC_eof, busy
    );

    // Trigger logic / DRAM / PC side.
    modport slave (
        output trig_valid, trig_time_stamp, DRAM_Read_Ready, DRAM_Read_data, DRAM_Read_Valid,
        input  trig_ready, trig_overflow, DRAM_Read_Enable, DRAM_Read_Addr,
               PC_data, PC_valid, PC_sof, PC_eof, busy
    );
endinterface

// File: rtl/trig_ts_fifo.sv
// Synchronous timestamp FIFO with occupancy count and a registered ready flag.
module trig_ts_fifo
    import trigger_readout_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [W-1:0]                din,
    input  logic                        pop,
    output logic [W-1:0]                dout,
    output logic                        full,
    output logic                        empty,
    output logic [clog2(DEPTH+1)-1:0]   count,
    output logic                        ready
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_n;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Next occupancy; simultaneous push and pop leaves it unchanged.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_n = count;
        if (do_push && !do_pop) begin
            count_n = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_n = count - CW'(1);
        end
    end

    // Pointers, occupancy and ready; ready tracks the occupancy it will have next cycle.
    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_n;
            ready <= (count_n != CW'(DEPTH));
        end
    end

    // Storage array written on push.
    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/trigger_readout_scheduler.sv
// Queues trigger timestamps and sequences windowed DRAM readouts framed toward the PC path.
module trigger_readout_scheduler
    import trigger_readout_pkg::*;
#(
    parameter int TS_W            = 16,
    parameter int ADDR_W          = 25,
    parameter int DATA_W          = 256,
    parameter int HEAD_DIFF       = DEFAULT_HEAD_DIFF,
    parameter int TAIL_DIFF       = DEFAULT_TAIL_DIFF,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    trigger_readout_scheduler_if.master bus
);
    localparam int WIN_LEN = win_len(HEAD_DIFF, TAIL_DIFF);
    localparam int CNT_W   = clog2(WIN_LEN + 1);
    localparam int OUT_W   = clog2(MAX_OUTSTANDING + 1);
    localparam int QC_W    = clog2(FIFO_DEPTH + 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] next_addr, next_addr_n, rd_addr, base;
    logic [CNT_W-1:0]  issue_left, issue_left_n, ret_cnt, ret_cnt_n;
    logic [OUT_W-1:0]  outstanding, outstanding_n;
    logic              rd_en, rd_en_n;
    logic              accept, ret_ok, pop;
    logic [TS_W-1:0]   fifo_dout;
    logic              fifo_full, fifo_empty;
    logic [QC_W-1:0]   fifo_count;
    logic              overflow_q;
    logic [DATA_W-1:0] pc_data_q;
    logic              pc_valid_q, pc_sof_q, pc_eof_q;

    trig_ts_fifo #(.W(TS_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.trig_valid),
        .din   (bus.trig_time_stamp),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .ready (bus.trig_ready)
    );

    // Window start; an underflowing head wraps around the address space.
    assign base   = ADDR_W'(fifo_dout) - ADDR_W'(HEAD_DIFF);
    assign accept = rd_en && bus.DRAM_Read_Ready;
    // Returns with nothing outstanding are strays (e.g. from before a reset) and are dropped.
    assign ret_ok = bus.DRAM_Read_Valid && (outstanding != '0);

    // Sequencing: next state, window counters, outstanding count and next read enable.
    always_comb begin
        state_n      = state;
        next_addr_n  = next_addr;
        issue_left_n = issue_left;
        ret_cnt_n    = ret_ok ? ret_cnt + CNT_W'(1) : ret_cnt;
        pop          = 1'b0;
        unique case ({accept, ret_ok})
            2'b10:   outstanding_n = outstanding + OUT_W'(1);
            2'b01:   outstanding_n = outstanding - OUT_W'(1);
            default: outstanding_n = outstanding;
        endcase
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    next_addr_n  = base;
                    issue_left_n = CNT_W'(WIN_LEN);
                    ret_cnt_n    = '0;
                    state_n      = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    next_addr_n  = next_addr + ADDR_W'(1);
                    issue_left_n = issue_left - CNT_W'(1);
                    if (issue_left == CNT_W'(1)) state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (ret_cnt == CNT_W'(WIN_LEN)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Enable counts this cycle's accept and return, so the limit is never exceeded.
        rd_en_n = (state_n == ISSUE) && (issue_left_n != '0) &&
                  (outstanding_n < OUT_W'(MAX_OUTSTANDING));
    end

    // Scheduler state, read request registers and drop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            next_addr   <= '0;
            issue_left  <= '0;
            ret_cnt     <= '0;
            outstanding <= '0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state       <= state_n;
            next_addr   <= next_addr_n;
            issue_left  <= issue_left_n;
            ret_cnt     <= ret_cnt_n;
            outstanding <= outstanding_n;
            rd_en       <= rd_en_n;
            if (rd_en_n) rd_addr <= next_addr_n;
            overflow_q  <= bus.trig_valid && fifo_full;
        end
    end

    // Output framing: counted returns delayed one cycle with window start/end markers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_data_q  <= '0;
            pc_valid_q <= 1'b0;
            pc_sof_q   <= 1'b0;
            pc_eof_q   <= 1'b0;
        end else begin
            pc_valid_q <= ret_ok;
            if (ret_ok) pc_data_q <= bus.DRAM_Read_data;
            pc_sof_q   <= ret_ok && (ret_cnt == '0);
            pc_eof_q   <= ret_ok && (ret_cnt == CNT_W'(WIN_LEN - 1));
        end
    end

    assign bus.trig_overflow    = overflow_q;
    assign bus.DRAM_Read_Enable = rd_en;
    assign bus.DRAM_Read_Addr   = rd_addr;
    assign bus.PC_data          = pc_data_q;
    assign bus.PC_valid         = pc_valid_q;
    assign bus.PC_sof           = pc_sof_q;
    assign bus.PC_eof           = pc_eof_q;
    assign bus.busy             = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_trigger_readout_scheduler.sv
// Scoreboard bench for trigger_readout_scheduler: a main instance (head 0, tail 10)
// and a second instance (head 5, tail 0) for address underflow.
module tb_trigger_readout_scheduler;
    localparam int TS_W = 16, ADDR_W = 25, DATA_W = 256, DEPTH = 4, MAX_OUT = 8;
    localparam int HD = 0, TD = 10, WIN = HD + TD + 1;
    localparam int W_HD = 5, W_TD = 0, W_WIN = W_HD + W_TD + 1;

    typedef struct { logic [DATA_W-1:0] data; logic sof; logic eof; } beat_t;
    typedef struct { logic [ADDR_W-1:0] addr; int due; } pend_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trigger_readout_scheduler_if #(.TS_W(TS_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    trigger_readout_scheduler_if #(.TS_W(TS_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) wbus ();

    trigger_readout_scheduler #(
        .TS_W(TS_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HEAD_DIFF(HD), .TAIL_DIFF(TD),
        .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    trigger_readout_scheduler #(
        .TS_W(TS_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HEAD_DIFF(W_HD), .TAIL_DIFF(W_TD),
        .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)
    ) dut_w (.clk(clk), .rst(rst), .bus(wbus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory contents seen by the bench: a fixed pattern derived from the address.
    function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = ({7'd0, a} * 32'(i + 3)) ^ 32'h5A00_00C3;
        return d;
    endfunction

    // ---------------- main instance scoreboard ----------------
    logic [ADDR_W-1:0] exp_addr[$];
    beat_t             exp_beat[$];
    int                acc_cyc[$];

    // Reference: a window is ts-HD .. ts+TD modulo the address space, framed first/last.
    task automatic push_window(input logic [TS_W-1:0] ts);
        logic [ADDR_W-1:0] a;
        beat_t b;
        for (int k = 0; k < WIN; k++) begin
            a = ADDR_W'(int'(ts) - HD + k);
            exp_addr.push_back(a);
            b.data = beat_data(a);
            b.sof  = (k == 0);
            b.eof  = (k == WIN - 1);
            exp_beat.push_back(b);
        end
    endtask

    // DRAM model for the main instance.
    int    cyc = 0;
    pend_t pend[$];
    int    ready_mode   = 1;   // 0 low, 1 high, 2 random
    int    valid_credit = -1;  // -1 unlimited
    bit    stray = 1'b0, rand_lat = 1'b0, rand_gap = 1'b0;

    initial begin : dram_model
        int due;
        bus.DRAM_Read_Ready = 1'b0;
        bus.DRAM_Read_Valid = 1'b0;
        bus.DRAM_Read_data  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            bus.DRAM_Read_Valid = 1'b0;
            if (rst) begin
                pend.delete();
            end else if (stray) begin
                bus.DRAM_Read_Valid = 1'b1;
                bus.DRAM_Read_data  = '1;
                stray = 1'b0;
            end else if (pend.size() > 0 && pend[0].due <= cyc && valid_credit != 0 &&
                         !(rand_gap && $urandom_range(3) == 0)) begin
                bus.DRAM_Read_Valid = 1'b1;
                bus.DRAM_Read_data  = beat_data(pend[0].addr);
                void'(pend.pop_front());
                if (valid_credit > 0) valid_credit--;
            end
            #1;
            case (ready_mode)
                0:       bus.DRAM_Read_Ready = 1'b0;
                1:       bus.DRAM_Read_Ready = 1'b1;
                default: bus.DRAM_Read_Ready = ($urandom_range(3) != 0);
            endcase
            @(negedge clk);
            if (!rst && bus.DRAM_Read_Enable && bus.DRAM_Read_Ready) begin
                due = cyc + 1 + (rand_lat ? int'($urandom_range(4, 1)) : 2);
                if (pend.size() > 0 && due < pend[$].due) due = pend[$].due;
                pend.push_back('{bus.DRAM_Read_Addr, due});
            end
        end
    end

    // Monitor: compares accepted addresses and PC beats against the scoreboard.
    int mon_out = 0, acc_total = 0, ovf_seen = 0, beats_seen = 0;

    initial begin : monitor
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_out = 0;
                continue;
            end
            if (bus.DRAM_Read_Valid && mon_out > 0) mon_out--;
            if (bus.PC_valid) begin
                beats_seen++;
                if (exp_beat.size() == 0) begin
                    check("pc_unexpected_beat", 1'b1, 1'b0);
                end else begin
                    b = exp_beat.pop_front();
                    check("pc_data", bus.PC_data, b.data);
                    check("pc_sof", bus.PC_sof, b.sof);
                    check("pc_eof", bus.PC_eof, b.eof);
                end
            end
            if (bus.DRAM_Read_Enable && bus.DRAM_Read_Ready) begin
                acc_total++;
                mon_out++;
                acc_cyc.push_back(cyc);
                check("outstanding_cap", (mon_out <= MAX_OUT), 1'b1);
                if (exp_addr.size() == 0) check("read_unexpected", 1'b1, 1'b0);
                else check("read_addr", bus.DRAM_Read_Addr, exp_addr.pop_front());
            end
            if (bus.trig_overflow) ovf_seen++;
        end
    end

    // ---------------- wrap instance: ready always high, one-cycle return ----------------
    logic [ADDR_W-1:0] w_exp_addr[$];
    beat_t             w_exp_beat[$];
    logic [ADDR_W-1:0] w_pend[$];
    int                w_beats = 0;

    initial begin : wrap_env
        beat_t b;
        wbus.DRAM_Read_Ready = 1'b1;
        wbus.DRAM_Read_Valid = 1'b0;
        wbus.DRAM_Read_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            wbus.DRAM_Read_Valid = 1'b0;
            if (w_pend.size() > 0) begin
                wbus.DRAM_Read_Valid = 1'b1;
                wbus.DRAM_Read_data  = beat_data(w_pend.pop_front());
            end
            @(negedge clk);
            if (!rst && wbus.PC_valid) begin
                w_beats++;
                if (w_exp_beat.size() == 0) begin
                    check("w_unexpected_beat", 1'b1, 1'b0);
                end else begin
                    b = w_exp_beat.pop_front();
                    check("w_pc_data", wbus.PC_data, b.data);
                    check("w_pc_sof", wbus.PC_sof, b.sof);
                    check("w_pc_eof", wbus.PC_eof, b.eof);
                end
            end
            if (!rst && wbus.DRAM_Read_Enable) begin
                w_pend.push_back(wbus.DRAM_Read_Addr);
                if (w_exp_addr.size() == 0) check("w_read_unexpected", 1'b1, 1'b0);
                else check("w_read_addr", wbus.DRAM_Read_Addr, w_exp_addr.pop_front());
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic send_trig(input logic [TS_W-1:0] ts);
        bus.trig_valid      = 1'b1;
        bus.trig_time_stamp = ts;
        tick();
        bus.trig_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_addr.size() != 0 || exp_beat.size() != 0 || bus.busy) && n < budget) begin
            tick();
            n++;
        end
        check(name, (n < budget), 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_enable"}, bus.DRAM_Read_Enable, 1'b0);
        check({tag, "_addr"}, bus.DRAM_Read_Addr, '0);
        check({tag, "_pc_valid"}, bus.PC_valid, 1'b0);
        check({tag, "_sof_eof"}, {bus.PC_sof, bus.PC_eof}, 2'b00);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_trig_ready"}, bus.trig_ready, 1'b0);
        check({tag, "_overflow"}, bus.trig_overflow, 1'b0);
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin : main_seq
        int n, base_acc, base_beats, base_ovf;
        logic [TS_W-1:0] ts;
        beat_t wb;
        bus.trig_valid       = 1'b0;
        bus.trig_time_stamp  = '0;
        wbus.trig_valid      = 1'b0;
        wbus.trig_time_stamp = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_pc_data", bus.PC_data, '0);
        rst = 1'b0;
        tick();
        check("trig_ready_after_reset", bus.trig_ready, 1'b1);

        // Single trigger at ts=100.
        acc_cyc.delete();
        base_beats = beats_seen;
        push_window(16'd100);
        send_trig(16'd100);
        n = 0;
        while (!bus.PC_eof && n < 100) begin
            tick();
            n++;
        end
        check("single_eof_seen", (n < 100), 1'b1);
        check("single_busy_at_eof", bus.busy, 1'b1);
        tick();
        check("single_busy_after_eof", bus.busy, 1'b0);
        wait_idle("single_done", 100);
        check("single_accepts", acc_cyc.size(), WIN);
        if (acc_cyc.size() == WIN) check("single_consecutive", acc_cyc[WIN-1] - acc_cyc[0], WIN - 1);
        check("single_beats", beats_seen - base_beats, WIN);

        // Underflow wrap on the second instance.
        for (int k = 0; k < W_WIN; k++) begin
            w_exp_addr.push_back(ADDR_W'(3 - W_HD + k));
            wb.data = beat_data(ADDR_W'(3 - W_HD + k));
            wb.sof  = (k == 0);
            wb.eof  = (k == W_WIN - 1);
            w_exp_beat.push_back(wb);
        end
        wbus.trig_valid      = 1'b1;
        wbus.trig_time_stamp = 16'd3;
        tick();
        wbus.trig_valid = 1'b0;
        n = 0;
        while ((w_exp_addr.size() != 0 || w_exp_beat.size() != 0 || wbus.busy) && n < 100) begin
            tick();
            n++;
        end
        check("wrap_done", (n < 100), 1'b1);
        check("wrap_beats", w_beats, W_WIN);

        // Backpressure at address 104.
        base_beats = beats_seen;
        push_window(16'd100);
        send_trig(16'd100);
        n = 0;
        while (!(bus.DRAM_Read_Enable && bus.DRAM_Read_Addr == ADDR_W'(104)) && n < 50) begin
            tick();
            n++;
        end
        check("bp_reach_104", (n < 50), 1'b1);
        ready_mode = 0;
        check("bp_hold_en", bus.DRAM_Read_Enable, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("bp_hold_en", bus.DRAM_Read_Enable, 1'b1);
            check("bp_hold_addr", bus.DRAM_Read_Addr, ADDR_W'(104));
        end
        ready_mode = 1;
        wait_idle("bp_done", 100);
        check("bp_beats", beats_seen - base_beats, WIN);

        // Outstanding cap with returns withheld.
        valid_credit = 0;
        base_acc = acc_total;
        push_window(16'd500);
        send_trig(16'd500);
        repeat (30) tick();
        check("cap_accepts", acc_total - base_acc, MAX_OUT);
        check("cap_enable_low", bus.DRAM_Read_Enable, 1'b0);
        valid_credit = 1;
        repeat (10) tick();
        check("cap_one_more", acc_total - base_acc, MAX_OUT + 1);
        check("cap_enable_low2", bus.DRAM_Read_Enable, 1'b0);
        valid_credit = -1;
        wait_idle("cap_done", 200);

        // Queue overflow: six back-to-back triggers while idle, the sixth dropped.
        base_ovf = ovf_seen;
        for (int i = 0; i < 5; i++) push_window(TS_W'(1000 + i * 37));
        for (int i = 0; i < 6; i++) begin
            if (i == 5) check("ovf_ready_low_when_full", bus.trig_ready, 1'b0);
            bus.trig_valid      = 1'b1;
            bus.trig_time_stamp = TS_W'(1000 + i * 37);
            tick();
        end
        bus.trig_valid = 1'b0;
        wait_idle("ovf_done", 800);
        check("ovf_pulses", ovf_seen - base_ovf, 1);

        // Reset in the middle of a window, then a stray return.
        base_acc = acc_total;
        push_window(16'd300);
        send_trig(16'd300);
        n = 0;
        while (acc_total - base_acc < 4 && n < 50) begin
            tick();
            n++;
        end
        check("rst_reach_4", (n < 50), 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        exp_addr.delete();
        exp_beat.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        stray = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stray_not_forwarded", bus.PC_valid, 1'b0);
        end
        base_beats = beats_seen;
        push_window(16'd200);
        send_trig(16'd200);
        wait_idle("after_rst_done", 100);
        check("after_rst_beats", beats_seen - base_beats, WIN);

        // Randomized traffic: random ready, latency, return gaps and trigger spacing.
        ready_mode = 2;
        rand_lat   = 1'b1;
        rand_gap   = 1'b1;
        base_ovf   = ovf_seen;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (bus.trig_ready && $urandom_range(5) == 0) begin
                ts = TS_W'($urandom);
                push_window(ts);
                bus.trig_valid      = 1'b1;
                bus.trig_time_stamp = ts;
            end else begin
                bus.trig_valid = 1'b0;
            end
        end
        tick();
        bus.trig_valid = 1'b0;
        wait_idle("random_done", 4000);
        check("random_no_overflow", ovf_seen - base_ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #800_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/trigger_readout_scheduler.md
Name: trigger_readout_scheduler

Overview:
- Queues trigger timestamps from the trigger logic and sequences windowed DRAM readouts, one trigger at a time.
- Each window covers the addresses [ts-HEAD_DIFF .. ts+TAIL_DIFF].
- Throttles DRAM read issue against an outstanding-read limit and DRAM ready.
- Frames returned beats toward the PC/UDP path with start/end markers.
- Sits between trigger detection and the DRAM read port, replacing ad-hoc single-trigger read sequencing.

Parameters:
- TS_W, 16, trigger timestamp width
- ADDR_W, 25, DRAM read address width
- DATA_W, 256, DRAM/PC data width
- HEAD_DIFF, 0, beats read before the timestamp
- TAIL_DIFF, 10, beats read after the timestamp
- FIFO_DEPTH, 4, trigger queue depth (power of 2)
- MAX_OUTSTANDING, 8, maximum issued-but-unreturned reads

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- trig_valid  in  1  trigger event strobe
- trig_time_stamp  in  TS_W  timestamp of the trigger
- trig_ready  out  1  queue not full
- trig_overflow  out  1  one-cycle pulse when a trigger is dropped
- DRAM_Read_Enable  out  1  read request
- DRAM_Read_Addr  out  ADDR_W  read address
- DRAM_Read_Ready  in  1  DRAM accepts the request this cycle
- DRAM_Read_data  in  DATA_W  returned data
- DRAM_Read_Valid  in  1  returned data valid
- PC_data  out  DATA_W  framed readout data
- PC_valid  out  1  PC_data valid
- PC_sof  out  1  first beat of a window
- PC_eof  out  1  last beat of a window
- busy  out  1  state != IDLE or queue non-empty

Behaviour:
- Reset values: all outputs 0; state IDLE; queue empty; all counters 0. trig_ready=1 one cycle after reset deasserts.
- WIN_LEN = HEAD_DIFF+TAIL_DIFF+1. Beat counters are clog2(WIN_LEN+1) bits wide.
- Queue:
  - Push when trig_valid && !full.
  - trig_valid && full drops the trigger and pulses trig_overflow. The drop happens even if a pop occurs in the same cycle.
  - trig_ready = !full, registered from the occupancy count.
- State IDLE:
  - If the queue is non-empty, pop the head.
  - base = zero-extended ts minus HEAD_DIFF, modulo 2^ADDR_W, so underflow wraps.
  - Load next_addr=base, issue_left=WIN_LEN, ret_cnt=0. Go to ISSUE.
- State ISSUE:
  - DRAM_Read_Enable is registered, asserted while issue_left>0 and outstanding<MAX_OUTSTANDING (outstanding counted including this cycle's accept).
  - DRAM_Read_Addr = next_addr while Enable is high.
  - A request is accepted on Enable && Ready. On accept: next_addr+1 (wraps modulo 2^ADDR_W), issue_left-1, outstanding+1.
  - Enable and Addr hold unchanged while Ready=0.
  - When the final request is accepted, deassert Enable the next cycle and go to DRAIN.
- State DRAIN: when ret_cnt reaches WIN_LEN, go to IDLE. The next trigger is popped no earlier than the following cycle.
- Outstanding counter:
  - +1 on accept, -1 on Valid; both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING.
  - Valid with outstanding=0 is ignored and not forwarded. This covers stray returns, including returns after a reset.
- Output framing:
  - PC_data/PC_valid = DRAM_Read_data/Valid registered, i.e. 1-cycle latency, for counted returns only.
  - PC_sof on the beat where ret_cnt==0.
  - PC_eof on the beat where ret_cnt==WIN_LEN-1.
  - If WIN_LEN==1, sof and eof are asserted together.
  - PC_data is don't-care when PC_valid=0 but must hold its last value.
- Reset mid-operation: asserting rst aborts the window immediately, clears the queue, and deasserts Enable and PC_valid asynchronously. Partial windows are not resumed.

Decomposition:
- Package trigger_readout_pkg:
  - state enum {IDLE, ISSUE, DRAIN}
  - WIN_LEN function/constant
  - clog2 helper
  - default HEAD_DIFF/TAIL_DIFF
- One sub-module, trig_ts_fifo: a synchronous FIFO, TS_W wide, FIFO_DEPTH deep, with full/empty/count and async active-high reset.

Test Plan:
- Single trigger: ts=100, HEAD_DIFF=0, TAIL_DIFF=10, Ready=1, Valid 2 cycles after each accept -> addresses 100..110 issued on 11 consecutive cycles; 11 PC_valid beats; sof on beat 0 only, eof on beat 10 only; busy drops after eof.
- Underflow wrap: HEAD_DIFF=5, TAIL_DIFF=0, ts=3 -> addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001, 0x0000002, 0x0000003.
- Backpressure: Ready low for 3 cycles mid-window at addr 104 -> Enable/Addr hold at 104; no beat skipped or duplicated; 11 beats total.
- Outstanding cap: Valid withheld -> exactly 8 accepts, then Enable=0. One Valid -> exactly one more issue. A simultaneous accept and Valid keeps the count at 8.
- Queue overflow: 6 triggers on consecutive cycles while idle -> t0 enters service, t1..t4 queued, t5 dropped with a single trig_overflow pulse. Windows are output in order t0..t4, each correctly framed.
- Reset mid-window: rst after the 4th accept, then a stray Valid -> all outputs 0; stray Valid not forwarded. A new trigger ts=200 yields a clean 11-beat window starting at 200.
